// File: rtl/bcd_seg_scan_driver.sv
// Five-position common-anode 7-segment scanner fed by a signed 4-digit BCD value.
// A frame snapshot is taken at each 4->0 slot wrap so the display never tears mid-scan.
module bcd_seg_scan_driver #(
    parameter int CLK_DIV  = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [16:0] bcd_in,
    output logic [4:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_ERR   = 7'h06;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [16:0]      snap;
    logic             tick;
    logic [6:0]       seg_nxt;
    logic [4:0]       an_nxt;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_ERR;
        endcase
        return s;
    endfunction

    // A digit is blanked only when it and every higher digit are zero; nibbles >9 count as nonzero.
    function automatic logic [6:0] slot_seg(input logic [2:0] i, input logic [16:0] s);
        logic       lz_en;
        logic       blk3;
        logic       blk2;
        logic       blk1;
        logic [6:0] r;
        lz_en = (BLANK_LZ != 0);
        blk3  = lz_en && (s[15:12] == 4'd0);
        blk2  = blk3  && (s[11:8]  == 4'd0);
        blk1  = blk2  && (s[7:4]   == 4'd0);
        case (i)
            3'd0:    r = seg_digit(s[3:0]);
            3'd1:    r = blk1 ? SEG_BLANK : seg_digit(s[7:4]);
            3'd2:    r = blk2 ? SEG_BLANK : seg_digit(s[11:8]);
            3'd3:    r = blk3 ? SEG_BLANK : seg_digit(s[15:12]);
            3'd4:    r = (s[16] && (s[15:0] != 16'h0)) ? SEG_MINUS : SEG_BLANK;
            default: r = SEG_BLANK;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] slot_an(input logic [2:0] i);
        logic [4:0] r;
        case (i)
            3'd0:    r = 5'h1E;
            3'd1:    r = 5'h1D;
            3'd2:    r = 5'h1B;
            3'd3:    r = 5'h17;
            3'd4:    r = 5'h0F;
            default: r = 5'h1F;
        endcase
        return r;
    endfunction

    assign tick = (cnt == CNT_MAX);

    always_comb begin
        seg_nxt = slot_seg(idx, snap);
        an_nxt  = slot_an(idx);
    end

    // Slot timing, snapshot and registered display outputs share one stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 3'd0;
            snap       <= 17'h0;
            an         <= 5'h1F;
            seg        <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (en) begin
                an  <= an_nxt;
                seg <= seg_nxt;
                if (tick) begin
                    cnt <= '0;
                    if (idx == 3'd4) begin
                        idx        <= 3'd0;
                        snap       <= bcd_in;
                        frame_done <= 1'b1;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                an  <= 5'h1F;
                seg <= SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan_driver.sv
// Directed bench: CLK_DIV=4 with and without blanking, plus a CLK_DIV=1 instance.
module tb_bcd_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic        en;
    logic [16:0] bcd_in;

    logic [4:0] an0, an_nb, an1;
    logic [6:0] seg0, seg_nb, seg1;
    logic       fd0, fd_nb, fd1;

    int tests = 0;
    int fails = 0;

    bcd_seg_scan_driver #(.CLK_DIV(4), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .en(en), .bcd_in(bcd_in),
        .an(an0), .seg(seg0), .frame_done(fd0)
    );

    bcd_seg_scan_driver #(.CLK_DIV(4), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .en(en), .bcd_in(bcd_in),
        .an(an_nb), .seg(seg_nb), .frame_done(fd_nb)
    );

    bcd_seg_scan_driver #(.CLK_DIV(1), .BLANK_LZ(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .bcd_in(bcd_in),
        .an(an1), .seg(seg1), .frame_done(fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        bcd_in = 17'h0;
        adv(2);
        chk("rst_an", 8'(an0), 8'h1F);
        chk("rst_seg", 8'(seg0), 8'h7F);
        chk("rst_fd", 8'(fd0), 8'h00);
        rst = 1'b0;

        // first frame after reset: snap=0
        adv(1);   // k=1
        chk("f1_s0_an", 8'(an0), 8'h1E);
        chk("f1_s0_seg", 8'(seg0), 8'h40);
        chk("f1_s0_fd", 8'(fd0), 8'h00);
        chk("d1_s0_an", 8'(an1), 8'h1E);
        chk("d1_s0_seg", 8'(seg1), 8'h40);
        adv(1);   // k=2
        chk("d1_s1_an", 8'(an1), 8'h1D);
        adv(2);   // k=4
        chk("d1_fd_lo", 8'(fd1), 8'h00);
        adv(1);   // k=5
        chk("d1_fd_hi", 8'(fd1), 8'h01);
        chk("f1_s1_an", 8'(an0), 8'h1D);
        chk("f1_s1_seg", 8'(seg0), 8'h7F);
        adv(4);   // k=9
        chk("f1_s2_an", 8'(an0), 8'h1B);
        chk("f1_s2_seg", 8'(seg0), 8'h7F);
        adv(4);   // k=13
        chk("f1_s3_an", 8'(an0), 8'h17);
        chk("f1_s3_seg", 8'(seg0), 8'h7F);
        adv(4);   // k=17
        chk("f1_s4_an", 8'(an0), 8'h0F);
        chk("f1_s4_seg", 8'(seg0), 8'h7F);
        bcd_in = 17'h10305;
        adv(2);   // k=19
        chk("f1_fd19", 8'(fd0), 8'h00);
        adv(1);   // k=20
        chk("f1_fd20", 8'(fd0), 8'h01);

        // frame showing -0305
        adv(1);   // k=21
        chk("f2_fd21", 8'(fd0), 8'h00);
        chk("f2_s0_an", 8'(an0), 8'h1E);
        chk("f2_s0_seg", 8'(seg0), 8'h12);
        adv(4);   // k=25
        chk("f2_s1_an", 8'(an0), 8'h1D);
        chk("f2_s1_seg", 8'(seg0), 8'h40);
        adv(4);   // k=29
        chk("f2_s2_an", 8'(an0), 8'h1B);
        chk("f2_s2_seg", 8'(seg0), 8'h30);
        adv(4);   // k=33
        chk("f2_s3_an", 8'(an0), 8'h17);
        chk("f2_s3_seg", 8'(seg0), 8'h7F);
        chk("f2_s3_seg_nb", 8'(seg_nb), 8'h40);
        adv(4);   // k=37
        chk("f2_s4_an", 8'(an0), 8'h0F);
        chk("f2_s4_seg", 8'(seg0), 8'h3F);
        adv(1);   // k=38
        bcd_in = 17'h10000;

        // negative zero, with and without blanking
        adv(3);   // k=41
        chk("nz_s0_seg", 8'(seg0), 8'h40);
        chk("nz_s0_seg_nb", 8'(seg_nb), 8'h40);
        adv(4);   // k=45
        chk("nz_s1_seg", 8'(seg0), 8'h7F);
        chk("nz_s1_seg_nb", 8'(seg_nb), 8'h40);
        adv(4);   // k=49
        chk("nz_s2_seg", 8'(seg0), 8'h7F);
        chk("nz_s2_seg_nb", 8'(seg_nb), 8'h40);
        adv(4);   // k=53
        chk("nz_s3_seg", 8'(seg0), 8'h7F);
        chk("nz_s3_seg_nb", 8'(seg_nb), 8'h40);
        chk("nz_s3_an_nb", 8'(an_nb), 8'h17);
        adv(4);   // k=57
        chk("nz_s4_an", 8'(an0), 8'h0F);
        chk("nz_s4_seg", 8'(seg0), 8'h7F);
        chk("nz_s4_seg_nb", 8'(seg_nb), 8'h7F);
        adv(1);   // k=58
        bcd_in = 17'h01234;

        // snapshot isolation: input changes while slot 2 is shown
        adv(3);   // k=61
        chk("si_s0_seg", 8'(seg0), 8'h19);
        adv(4);   // k=65
        chk("si_s1_seg", 8'(seg0), 8'h30);
        adv(4);   // k=69
        chk("si_s2_seg", 8'(seg0), 8'h24);
        bcd_in = 17'h09876;
        adv(4);   // k=73
        chk("si_s3_seg", 8'(seg0), 8'h79);
        adv(4);   // k=77
        chk("si_s4_an", 8'(an0), 8'h0F);
        chk("si_s4_seg", 8'(seg0), 8'h7F);
        adv(4);   // k=81
        chk("si2_s0_seg", 8'(seg0), 8'h02);
        adv(4);   // k=85
        chk("si2_s1_seg", 8'(seg0), 8'h78);
        adv(4);   // k=89
        chk("si2_s2_seg", 8'(seg0), 8'h00);
        adv(4);   // k=93
        chk("si2_s3_seg", 8'(seg0), 8'h10);
        adv(4);   // k=97
        chk("si2_s4_seg", 8'(seg0), 8'h7F);
        adv(1);   // k=98
        bcd_in = 17'h0A001;

        // invalid nibble in thousands keeps lower zeros visible
        adv(3);   // k=101
        chk("inv_s0_seg", 8'(seg0), 8'h79);
        adv(4);   // k=105
        chk("inv_s1_seg", 8'(seg0), 8'h40);
        adv(4);   // k=109
        chk("inv_s2_seg", 8'(seg0), 8'h40);
        adv(4);   // k=113
        chk("inv_s3_an", 8'(an0), 8'h17);
        chk("inv_s3_seg", 8'(seg0), 8'h06);

        // enable drop for 10 cycles with residual count 2 in slot 3
        adv(1);   // k=114
        en = 1'b0;
        adv(1);   // k=115
        chk("en0_an", 8'(an0), 8'h1F);
        chk("en0_seg", 8'(seg0), 8'h7F);
        adv(9);   // k=124
        chk("en0_an_end", 8'(an0), 8'h1F);
        chk("en0_seg_end", 8'(seg0), 8'h7F);
        chk("en0_fd", 8'(fd0), 8'h00);
        en = 1'b1;
        adv(1);   // k=125
        chk("en1_an125", 8'(an0), 8'h17);
        chk("en1_seg125", 8'(seg0), 8'h06);
        adv(1);   // k=126
        chk("en1_an126", 8'(an0), 8'h17);
        adv(1);   // k=127
        chk("en1_an127", 8'(an0), 8'h0F);
        chk("en1_seg127", 8'(seg0), 8'h7F);
        adv(2);   // k=129
        chk("en1_fd129", 8'(fd0), 8'h00);
        adv(1);   // k=130
        chk("en1_fd130", 8'(fd0), 8'h01);
        adv(1);   // k=131
        chk("en1_s0_an", 8'(an0), 8'h1E);
        chk("en1_s0_seg", 8'(seg0), 8'h79);
        adv(13);  // k=144
        chk("ar_pre_an", 8'(an0), 8'h17);
        chk("ar_pre_seg", 8'(seg0), 8'h06);

        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("ar_an", 8'(an0), 8'h1F);
        chk("ar_seg", 8'(seg0), 8'h7F);
        chk("ar_fd", 8'(fd0), 8'h00);
        adv(2);
        chk("ar_hold_an", 8'(an0), 8'h1F);
        rst = 1'b0;
        adv(1);   // k=1
        chk("ar_s0_an", 8'(an0), 8'h1E);
        chk("ar_s0_seg", 8'(seg0), 8'h40);
        adv(16);  // k=17
        chk("ar_s4_an", 8'(an0), 8'h0F);
        chk("ar_s4_seg", 8'(seg0), 8'h7F);
        adv(2);   // k=19
        chk("ar_fd19", 8'(fd0), 8'h00);
        adv(1);   // k=20
        chk("ar_fd20", 8'(fd0), 8'h01);
        adv(1);   // k=21
        chk("ar_f2_s0_seg", 8'(seg0), 8'h79);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_seg_scan_driver.md
Name: bcd_seg_scan_driver

Overview:
Time-multiplexed 7-segment display driver directly downstream of the 16-bit binary-to-BCD converter. Consumes its 17-bit output: bit 16 is the sign, bits 15:0 are four BCD digits (thousands..ones). Scans five common-anode digit positions (four magnitude digits plus a sign position) with leading-zero blanking. Latches a frame snapshot so the displayed value never tears mid-scan.

Parameters:
CLK_DIV, 50000, clocks per digit slot (tick period); legal range >= 1
BLANK_LZ, 1, 1 = blank leading zeros; 0 = show all four digits

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
en  in  1  display enable; 0 = all digits dark, scan frozen
bcd_in  in  17  {sign, thou[3:0], hund[3:0], tens[3:0], ones[3:0]} from converter
an  out  5  digit anodes, active-low; an[0]=ones .. an[3]=thousands, an[4]=sign
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
frame_done  out  1  one-cycle pulse when the slot index wraps 4->0

Behaviour:
- Reset (async, rst=1): prescaler=0, idx=0, snap=17'h0, an=5'h1F, seg=7'h7F, frame_done=0. All state registers sit on the async reset.
- Prescaler counts 0..CLK_DIV-1 while en=1. tick=1 when count==CLK_DIV-1, then count wraps to 0. With CLK_DIV=1, tick is asserted every cycle.
- On tick: idx advances 0,1,2,3,4,0... If idx==4 on the tick: snap<=bcd_in, frame_done<=1 for that one cycle, idx<=0. bcd_in is sampled only at this edge.
- an/seg are registered decodes of the current idx and snap. They update on the clock edge after idx changes, so latency is 1 clk. an has exactly one bit low per slot.
- Digit decode, BCD to seg:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex)
  - Nibble >9 shows 'E' = 06
  - Blank = 7F; '-' = 3F
- Leading-zero blanking (BLANK_LZ=1): digit k (k=3..1) is blank if it and every higher digit are 0. Ones is never blanked. Invalid nibbles (>9) count as nonzero. With BLANK_LZ=0, no blanking.
- Sign slot (idx=4): shows '-' only if snap[16]=1 and snap[15:0]!=0. Otherwise blank, so -0 displays as "0".
- en=0:
  - Prescaler and idx hold.
  - an<=5'h1F and seg<=7'h7F on the next edge.
  - No snapshot, no frame_done.
- en rising: scan resumes from the held count/idx.
- en=0 takes priority over a coincident tick.
- Reset mid-frame: immediate return to reset values. First frame after reset displays snap=0 (ones shows "0", other slots blank) until the first wrap loads bcd_in.

Test Plan:
- Reset/first frame: CLK_DIV=4, BLANK_LZ=1, assert rst, release. Require an=1F/seg=7F during reset. Then slot 0 shows an=1E, seg=40 and slots 1-4 show seg=7F. frame_done pulses once at cycle 20.
- Value with sign: bcd_in=17'h10305 (-0305), CLK_DIV=4. In the second frame require:
  - idx0 an=1E seg=12 ('5')
  - idx1 an=1D seg=40 ('0')
  - idx2 an=1B seg=30 ('3')
  - idx3 an=17 seg=7F (blanked)
  - idx4 an=0F seg=3F ('-')
- Negative zero and no blanking: bcd_in=17'h10000 -> sign slot 7F, ones 40, others 7F. Same input with BLANK_LZ=0 -> thousands..ones all 40, sign 7F.
- Snapshot isolation: change bcd_in from 17'h01234 to 17'h09876 at mid-frame (idx=2). Remaining slots of that frame still show 1234 digits; 9876 appears only after frame_done.
- Invalid nibble and enable: bcd_in=17'h0A001 -> thousands shows 06, hundreds and tens show 40 (not blanked). Drop en for 10 cycles -> an=1F, seg=7F, idx and prescaler frozen; re-raise -> scan resumes at the same slot with the same residual count.
- Async reset mid-frame: assert rst between clock edges at idx=3 -> an=1F, seg=7F, frame_done=0 immediately without a clock edge; on release, behaviour matches the first-frame scenario.
